pingpong_initiator: RTL

Clocked four-phase request/acknowledge initiator that drives the "ping" side of a ping/pong exchange and counts completed round trips. It sits directly upstream of the event-driven responder stage in the dynamic-scheduling regression designs: it raises `ping_req`, waits for the responder's `pong_ack`, and repeats until a programmed number of rounds has completed. An optional watchdog flags a responder that never answers.

---
 rtl/pingpong_pkg.sv | 22 ++
 rtl/pingpong_watchdog.sv | 36 +++
 rtl/pingpong_initiator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the ping/pong initiator and its watchdog.
package pingpong_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        REL  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } pp_state_e;

    localparam int unsigned PP_DEFAULT_ROUNDS  = 5;
    localparam int unsigned PP_DEFAULT_TIMEOUT = 16;
    localparam int unsigned PP_DEFAULT_CNT_W   = 8;

    // True while the initiator is waiting on the responder in either handshake phase.
    function automatic logic pp_in_phase(input pp_state_e s);
        return (s == REQ) || (s == REL);
    endfunction

endpackage

// File: rtl/pingpong_watchdog.sv
// Per-phase cycle counter that flags a responder which stops answering.
// Only instantiated when PINGPONG_WATCHDOG_EN is defined.
module pingpong_watchdog
    import pingpong_pkg::*;
#(
    parameter int unsigned TIMEOUT = PP_DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    // The counter only ever needs to reach TIMEOUT-1: expiry is taken on the edge after that.
    localparam int unsigned LP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(TIMEOUT - 1);

    logic [LP_W-1:0] r_cnt;
    logic            w_at_last;

    assign w_at_last = (r_cnt == LP_LAST);
    assign o_expired = i_run && w_at_last;

    // Count cycles spent in the current phase; saturate so the count can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pingpong_initiator.sv
// Four-phase ping initiator: raises ping_req, waits for pong_ack to rise and
// fall, and repeats for ROUNDS round trips. Optional watchdog enabled by
// defining PINGPONG_WATCHDOG_EN; without it error stays 0 and ERR is unreachable.
module pingpong_initiator
    import pingpong_pkg::*;
#(
    parameter int unsigned ROUNDS  = PP_DEFAULT_ROUNDS,
    parameter int unsigned CNT_W   = PP_DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT = PP_DEFAULT_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pong_ack,
    output logic             o_ping_req,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_rounds,
    output logic             o_error
);

    if (ROUNDS >= (64'd1 << CNT_W)) begin : g_bad_rounds
        $fatal(1, "pingpong_initiator: ROUNDS does not fit in CNT_W bits");
    end

    if (TIMEOUT < 1) begin : g_bad_timeout
        $fatal(1, "pingpong_initiator: TIMEOUT must be at least 1");
    end

    localparam logic [CNT_W-1:0] LP_ROUNDS      = CNT_W'(ROUNDS);
    localparam logic             LP_ZERO_ROUNDS = (ROUNDS == 0);

    pp_state_e        r_state;
    logic             r_ping_req;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [CNT_W-1:0] r_rounds;
    logic             w_start_ok;
    logic             w_expired;

    // A start is only honoured once the responder has released its acknowledge.
    assign w_start_ok = i_start && !i_pong_ack;

`ifdef PINGPONG_WATCHDOG_EN
    logic w_wd_run;
    logic w_wd_clear;

    // Restart the count on REQ->REL, and hold it at zero outside the two phases
    // so every entry into REQ or REL begins from zero.
    assign w_wd_run   = pp_in_phase(r_state);
    assign w_wd_clear = !w_wd_run || ((r_state == REQ) && i_pong_ack);

    pingpong_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_wd_clear),
        .i_run     (w_wd_run),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Handshake sequencer with all outputs registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_ping_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_rounds   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, ERR: begin
                    if (w_start_ok) begin
                        r_rounds <= '0;
                        r_error  <= 1'b0;
                        r_busy   <= 1'b1;
                        if (LP_ZERO_ROUNDS) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= REQ;
                            r_ping_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (i_abort) begin
                        r_state    <= IDLE;
                        r_ping_req <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (i_pong_ack) begin
                        r_state    <= REL;
                        r_ping_req <= 1'b0;
                    end else if (w_expired) begin
                        r_state    <= ERR;
                        r_ping_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                    end
                end
                REL: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (!i_pong_ack) begin
                        r_state  <= NEXT;
                        r_rounds <= r_rounds + 1'b1;
                    end else if (w_expired) begin
                        r_state <= ERR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end
                end
                NEXT: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_rounds == LP_ROUNDS) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= REQ;
                        r_ping_req <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_ping_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_ping_req = r_ping_req;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rounds   = r_rounds;
    assign o_error    = r_error;

endmodule
